// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 pooling over a raster-order activation stream.
// Define POOL_AVG_EN to add the per-frame average mode alongside max pooling.
module pool2x2_stream #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IMG_W     = 4,
  parameter int unsigned IMG_H     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned SIGNED    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act_valid_i,
  input  logic [DATA_W-1:0] act_result_i,
  input  logic [ADDR_W-1:0] act_result_address_i,
  input  logic              act_last_i,
  input  logic              mode_i,
  output logic              pool_valid_o,
  output logic [DATA_W-1:0] pool_result_o,
  output logic [ADDR_W-1:0] pool_result_address_o,
  output logic              pool_last_o,
  output logic              frame_err_o
);

  localparam int unsigned HALF_W = IMG_W / 2;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned LBI_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned LB_W   = DATA_W + 1;
`else
  localparam int unsigned LB_W   = DATA_W;
`endif

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(ADDR_BASE);

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic a_gt;
    if (SIGNED != 0) a_gt = $signed(a) > $signed(b);
    else             a_gt = a > b;
    return a_gt ? a : b;
  endfunction

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] partner_q, partner_d;
  logic              ovr_q, ovr_d;
  logic [LB_W-1:0]   lb_q [HALF_W];
  logic [LB_W-1:0]   lb_d [HALF_W];

  logic              pool_valid_q, pool_valid_d;
  logic [DATA_W-1:0] pool_result_q, pool_result_d;
  logic [ADDR_W-1:0] pool_addr_q, pool_addr_d;
  logic              pool_last_q, pool_last_d;
  logic              frame_err_q, frame_err_d;

  logic [LBI_W-1:0]  lb_idx;
  logic [LB_W-1:0]   lb_rd;
  logic [LB_W-1:0]   lb_wr;
  logic [DATA_W-1:0] h_max;
  logic [DATA_W-1:0] win_res;
  logic              at_end;
  logic              first;
  logic              unused_inputs;

  assign lb_idx = LBI_W'(col_q >> 1);
  assign lb_rd  = lb_q[lb_idx];
  assign h_max  = max2(partner_q, act_result_i);
  assign at_end = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign first  = (col_q == '0) && (row_q == '0);

`ifdef POOL_AVG_EN
  logic              mode_q, mode_d;
  logic              mode_eff;
  logic [DATA_W:0]   h_sum;
  logic [DATA_W+1:0] total;
  logic              ext_p, ext_s, ext_l, ext_h;

  // Mode is taken live on a frame's first sample so the latch never lags it.
  assign mode_eff = first ? mode_i : mode_q;
  assign ext_p    = (SIGNED != 0) & partner_q[DATA_W-1];
  assign ext_s    = (SIGNED != 0) & act_result_i[DATA_W-1];
  assign h_sum    = {ext_p, partner_q} + {ext_s, act_result_i};
  assign ext_l    = (SIGNED != 0) & lb_rd[DATA_W];
  assign ext_h    = (SIGNED != 0) & h_sum[DATA_W];
  // Dropping the two LSBs floors the sum for both signed and unsigned data.
  assign total    = {ext_l, lb_rd} + {ext_h, h_sum};
  assign lb_wr    = mode_eff ? h_sum : {1'b0, h_max};
  assign win_res  = mode_eff ? total[DATA_W+1:2]
                             : max2(h_max, lb_rd[DATA_W-1:0]);
  assign unused_inputs = ^{act_result_address_i, total[1:0]};
`else
  assign lb_wr    = h_max;
  assign win_res  = max2(h_max, lb_rd);
  assign unused_inputs = ^{act_result_address_i, mode_i};
`endif

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    idx_d         = idx_q;
    partner_d     = partner_q;
    ovr_d         = ovr_q;
    lb_d          = lb_q;
    pool_valid_d  = 1'b0;
    pool_last_d   = 1'b0;
    frame_err_d   = 1'b0;
    pool_result_d = pool_result_q;
    pool_addr_d   = pool_addr_q;
`ifdef POOL_AVG_EN
    mode_d        = mode_q;
`endif
    if (act_valid_i) begin
      if (ovr_q || (act_last_i && !at_end)) begin
        // Offending sample closes the aborted frame; its window is dropped.
        frame_err_d = 1'b1;
        col_d       = '0;
        row_d       = '0;
        idx_d       = '0;
        ovr_d       = 1'b0;
      end else begin
`ifdef POOL_AVG_EN
        if (first) mode_d = mode_i;
`endif
        if (!col_q[0]) begin
          partner_d = act_result_i;
        end else if (!row_q[0]) begin
          lb_d[lb_idx] = lb_wr;
        end else begin
          pool_valid_d  = 1'b1;
          pool_result_d = win_res;
          pool_addr_d   = BASE + idx_q;
          idx_d         = idx_q + ADDR_W'(1);
        end
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (act_last_i) begin
              pool_last_d = 1'b1;
              idx_d       = '0;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      idx_q         <= '0;
      partner_q     <= '0;
      ovr_q         <= 1'b0;
      pool_valid_q  <= 1'b0;
      pool_result_q <= '0;
      pool_addr_q   <= BASE;
      pool_last_q   <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef POOL_AVG_EN
      mode_q        <= 1'b0;
`endif
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      idx_q         <= idx_d;
      partner_q     <= partner_d;
      ovr_q         <= ovr_d;
      pool_valid_q  <= pool_valid_d;
      pool_result_q <= pool_result_d;
      pool_addr_q   <= pool_addr_d;
      pool_last_q   <= pool_last_d;
      frame_err_q   <= frame_err_d;
`ifdef POOL_AVG_EN
      mode_q        <= mode_d;
`endif
    end
  end

  // Line buffer is always written on an even row before it is read.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

  assign pool_valid_o          = pool_valid_q;
  assign pool_result_o         = pool_result_q;
  assign pool_result_address_o = pool_addr_q;
  assign pool_last_o           = pool_last_q;
  assign frame_err_o           = frame_err_q;

endmodule
